// File: rtl/rx_guess_ctrl.sv
// rx_guess_ctrl: frames a header byte followed by a guess letter from uart_rx,
// validates and uppercases the letter, holds it for the game logic, and
// tracks parity / bad-letter / timeout events in a saturating counter.
module rx_guess_ctrl #(
  parameter logic [7:0]  HDR_BYTE     = 8'h47,
  parameter int unsigned TIMEOUT_CLKS = 12500
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic       rx_ready,
  input  logic [7:0] rx_byte,
  input  logic       parity_err,
  input  logic       game_ack,
  input  logic       err_clr,
  output logic       rec_ready,
  output logic [7:0] guess,
  output logic       guess_valid,
  output logic       timeout,
  output logic [3:0] err_count
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [3:0] ERR_MAX = 4'hF;

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    WAIT_LTR = 2'd1,
    CHECK    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          en_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    ltr_q, ltr_d;
  logic [7:0]    guess_d;
  logic          err_inc;
  logic          timeout_d;
  logic          rx_acc;

  // Next-state, timer, letter latch and event decode
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    ltr_d     = ltr_q;
    guess_d   = guess;
    err_inc   = 1'b0;
    timeout_d = 1'b0;
    rx_acc    = rx_ready & rec_ready;

    if (!en_q) begin
      state_d = WAIT_HDR;
    end else begin
      case (state_q)
        WAIT_HDR: begin
          if (rx_acc) begin
            if (parity_err) begin
              err_inc = 1'b1;
            end else if (rx_byte == HDR_BYTE) begin
              state_d = WAIT_LTR;
            end
          end
        end
        WAIT_LTR: begin
          // A byte arriving on the expiry cycle wins over the timeout
          if (rx_acc) begin
            if (parity_err) begin
              err_inc = 1'b1;
              state_d = WAIT_HDR;
            end else if (rx_byte == HDR_BYTE) begin
              timer_d = '0;
            end else begin
              ltr_d   = rx_byte;
              state_d = CHECK;
            end
          end else if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            err_inc   = 1'b1;
            state_d   = WAIT_HDR;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        CHECK: begin
          if (ltr_q >= 8'h41 && ltr_q <= 8'h5A) begin
            guess_d = ltr_q;
            state_d = HOLD;
          end else if (ltr_q >= 8'h61 && ltr_q <= 8'h7A) begin
            guess_d = ltr_q - 8'h20;
            state_d = HOLD;
          end else begin
            err_inc = 1'b1;
            state_d = WAIT_HDR;
          end
        end
        HOLD: begin
          if (game_ack) state_d = WAIT_HDR;
        end
        default: state_d = WAIT_HDR;
      endcase
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= WAIT_HDR;
      en_q        <= 1'b0;
      timer_q     <= '0;
      ltr_q       <= 8'h00;
      guess       <= 8'h00;
      guess_valid <= 1'b0;
      timeout     <= 1'b0;
      rec_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= enable;
      timer_q     <= timer_d;
      ltr_q       <= ltr_d;
      guess       <= guess_d;
      guess_valid <= (state_d == HOLD);
      timeout     <= timeout_d;
      rec_ready   <= enable && (state_d == WAIT_HDR || state_d == WAIT_LTR);
    end
  end

  // Saturating error counter; clear wins over a same-cycle event
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      err_count <= 4'h0;
    end else if (err_clr) begin
      err_count <= 4'h0;
    end else if (err_inc && err_count != ERR_MAX) begin
      err_count <= err_count + 4'h1;
    end
  end

endmodule

// File: tb/tb_rx_guess_ctrl.sv
// Directed testbench for rx_guess_ctrl with hand-computed expectations.
module tb_rx_guess_ctrl;

  localparam int unsigned TOUT = 20;

  logic       tb_clk;
  logic       nrst;
  logic       enable;
  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       parity_err;
  logic       game_ack;
  logic       err_clr;
  logic       rec_ready;
  logic [7:0] guess;
  logic       guess_valid;
  logic       timeout;
  logic [3:0] err_count;

  int errors = 0;
  int checks = 0;

  rx_guess_ctrl #(.HDR_BYTE(8'h47), .TIMEOUT_CLKS(TOUT)) dut (
    .clk         (tb_clk),
    .nRst        (nrst),
    .enable      (enable),
    .rx_ready    (rx_ready),
    .rx_byte     (rx_byte),
    .parity_err  (parity_err),
    .game_ack    (game_ack),
    .err_clr     (err_clr),
    .rec_ready   (rec_ready),
    .guess       (guess),
    .guess_valid (guess_valid),
    .timeout     (timeout),
    .err_count   (err_count)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // One-cycle rx_ready pulse; returns one cycle later
  task automatic pulse(input logic [7:0] b, input logic perr);
    rx_ready   = 1'b1;
    rx_byte    = b;
    parity_err = perr;
    step(1);
    rx_ready   = 1'b0;
    parity_err = 1'b0;
  endtask

  task automatic ack();
    game_ack = 1'b1;
    step(1);
    game_ack = 1'b0;
  endtask

  logic [7:0] tbl_byte  [8];
  logic       tbl_ok    [8];
  logic [7:0] tbl_guess [8];
  int         tcount;
  int         tat;

  initial begin
    tbl_byte  = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};
    tbl_ok    = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    tbl_guess = '{8'h00, 8'h41, 8'h5A, 8'h00, 8'h00, 8'h41, 8'h5A, 8'h00};

    nrst = 1'b0; enable = 1'b0; rx_ready = 1'b0; rx_byte = 8'h00;
    parity_err = 1'b0; game_ack = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_rec_ready", 8'(rec_ready), 8'h0);
    chk("rst_guess", guess, 8'h00);
    chk("rst_gv", 8'(guess_valid), 8'h0);
    chk("rst_timeout", 8'(timeout), 8'h0);
    chk("rst_err", 8'(err_count), 8'h0);
    #10 nrst = 1'b1;
    step(1);
    chk("dis_rec_ready", 8'(rec_ready), 8'h0);
    enable = 1'b1;
    step(2);
    chk("en_rec_ready", 8'(rec_ready), 8'h1);

    // Basic frame: 'G' 'b' -> 'B'
    pulse(8'h47, 1'b0);
    pulse(8'h62, 1'b0);
    chk("lat_n1_gv", 8'(guess_valid), 8'h0);
    step(1);
    chk("lat_n2_gv", 8'(guess_valid), 8'h1);
    chk("lat_n2_guess", guess, 8'h42);
    chk("hold_rec_ready", 8'(rec_ready), 8'h0);
    step(3);
    chk("hold_gv", 8'(guess_valid), 8'h1);
    chk("hold_guess", guess, 8'h42);
    ack();
    chk("ack_gv", 8'(guess_valid), 8'h0);
    chk("ack_guess", guess, 8'h42);
    chk("ack_rec_ready", 8'(rec_ready), 8'h1);

    // Letter timeout
    pulse(8'h47, 1'b0);
    tcount = 0; tat = -1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (timeout) begin
        tcount++;
        if (tat < 0) tat = i;
      end
    end
    chk("tout_pulses", 8'(tcount), 8'd1);
    chk("tout_at", 8'(tat), 8'd19);
    chk("tout_err", 8'(err_count), 8'h1);
    chk("tout_rec_ready", 8'(rec_ready), 8'h1);

    // Byte on the expiry cycle beats the timeout
    pulse(8'h47, 1'b0);
    step(TOUT - 1);
    pulse(8'h44, 1'b0);
    chk("edge_tout0", 8'(timeout), 8'h0);
    step(1);
    chk("edge_tout1", 8'(timeout), 8'h0);
    chk("edge_gv", 8'(guess_valid), 8'h1);
    chk("edge_guess", guess, 8'h44);
    chk("edge_err", 8'(err_count), 8'h1);
    ack();

    // Non-letter, then header resync
    pulse(8'h47, 1'b0);
    pulse(8'h31, 1'b0);
    step(1);
    chk("bad_gv", 8'(guess_valid), 8'h0);
    chk("bad_err", 8'(err_count), 8'h2);
    chk("bad_guess", guess, 8'h44);
    pulse(8'h47, 1'b0);
    pulse(8'h47, 1'b0);
    pulse(8'h5A, 1'b0);
    step(1);
    chk("resync_gv", 8'(guess_valid), 8'h1);
    chk("resync_guess", guess, 8'h5A);
    ack();

    // Range boundaries of letter acceptance
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse(8'h47, 1'b0);
      pulse(tbl_byte[i], 1'b0);
      step(1);
      chk($sformatf("tbl_gv_%0h", tbl_byte[i]), 8'(guess_valid), 8'(tbl_ok[i]));
      if (tbl_ok[i]) begin
        chk($sformatf("tbl_guess_%0h", tbl_byte[i]), guess, tbl_guess[i]);
        ack();
      end
    end
    chk("tbl_err", 8'(err_count), 8'h4);

    // Parity errors, saturation, clear
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    pulse(8'h47, 1'b0);
    pulse(8'h41, 1'b1);
    step(1);
    chk("par_ltr_gv", 8'(guess_valid), 8'h0);
    chk("par_ltr_err", 8'(err_count), 8'h1);
    for (int i = 0; i < 16; i++) pulse(8'h00, 1'b1);
    chk("sat_err", 8'(err_count), 8'hF);
    err_clr = 1'b1;
    pulse(8'h00, 1'b1);
    err_clr = 1'b0;
    chk("clr_wins", 8'(err_count), 8'h0);

    // Traffic during HOLD is ignored; disable drops the guess
    pulse(8'h47, 1'b0);
    pulse(8'h63, 1'b0);
    step(1);
    chk("h_guess", guess, 8'h43);
    pulse(8'h47, 1'b0);
    pulse(8'h5A, 1'b1);
    pulse(8'h58, 1'b0);
    chk("h_ign_guess", guess, 8'h43);
    chk("h_ign_gv", 8'(guess_valid), 8'h1);
    chk("h_ign_err", 8'(err_count), 8'h0);
    enable = 1'b0;
    step(2);
    chk("dis_gv", 8'(guess_valid), 8'h0);
    chk("dis_rr", 8'(rec_ready), 8'h0);
    chk("dis_guess", guess, 8'h43);
    enable = 1'b1;
    step(2);
    chk("reen_rr", 8'(rec_ready), 8'h1);

    // Reset between header and letter
    pulse(8'h00, 1'b1);
    chk("pre_rst_err", 8'(err_count), 8'h1);
    pulse(8'h47, 1'b0);
    nrst = 1'b0;
    #2;
    chk("mid_rst_rr", 8'(rec_ready), 8'h0);
    chk("mid_rst_gv", 8'(guess_valid), 8'h0);
    chk("mid_rst_guess", guess, 8'h00);
    chk("mid_rst_err", 8'(err_count), 8'h0);
    chk("mid_rst_tout", 8'(timeout), 8'h0);
    #2 nrst = 1'b1;
    step(1);
    pulse(8'h45, 1'b0);
    tcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (guess_valid) tcount++;
      step(1);
    end
    chk("post_rst_gv", 8'(tcount), 8'd0);
    chk("post_rst_err", 8'(err_count), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_guess_ctrl.md
RX_GUESS_CTRL -- requirements
Module: rx_guess_ctrl

Interface
REQ-001 Parameter HDR_BYTE, default 8'h47 ('G'), frame header byte that precedes every guess letter.
REQ-002 Parameter TIMEOUT_CLKS, default 12500, max clocks allowed between header accept and letter arrival.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be asynchronous and active-low, nRst.
REQ-004 clk  input  1  system clock.
REQ-005 nRst  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  controller enable; low forces idle.
REQ-007 rx_ready  input  1  one-cycle pulse from uart_rx; rx_byte valid that cycle.
REQ-008 rx_byte  input  8  received byte from uart_rx.
REQ-009 parity_err  input  1  parity error for the byte flagged by rx_ready (OR of uart_rx error outputs).
REQ-010 game_ack  input  1  game logic has consumed guess.
REQ-011 err_clr  input  1  clears err_count.
REQ-012 rec_ready  output  1  to uart_rx; controller can accept a byte.
REQ-013 guess  output  8  validated uppercase ASCII letter.
REQ-014 guess_valid  output  1  guess available; held until game_ack.
REQ-015 timeout  output  1  one-cycle pulse on letter timeout.
REQ-016 err_count  output  4  saturating count of parity, bad-letter and timeout events.

Function
REQ-017 States SHALL be WAIT_HDR, WAIT_LTR, CHECK, HOLD; a registered en_q SHALL sample enable each cycle.
REQ-018 rec_ready SHALL equal en_q AND (state is WAIT_HDR or WAIT_LTR).
REQ-019 rx_ready while rec_ready=0 SHALL be ignored (no state change, no count).
REQ-020 WAIT_HDR: rx_ready with parity_err=1 -> err_count+1, stay; rx_ready with rx_byte==HDR_BYTE and parity_err=0 -> WAIT_LTR, timer=0; any other byte -> ignored, stay.
REQ-021 WAIT_LTR: timer SHALL increment every cycle; timer reaching TIMEOUT_CLKS-1 with no rx_ready -> timeout pulse, err_count+1, WAIT_HDR.
REQ-022 WAIT_LTR: rx_ready with parity_err=1 -> err_count+1, WAIT_HDR; rx_byte==HDR_BYTE -> stay, timer=0 (resync); otherwise latch rx_byte -> CHECK.
REQ-023 rx_ready on the same cycle the timer expires SHALL take precedence over timeout.
REQ-024 CHECK (one cycle): latched byte in 8'h41-8'h5A -> guess=byte; 8'h61-8'h7A -> guess=byte-8'h20; either -> HOLD; else err_count+1, WAIT_HDR, guess unchanged.
REQ-025 Latency: letter rx_ready at cycle N SHALL give guess_valid=1 at cycle N+2.
REQ-026 HOLD: guess_valid=1, guess stable; game_ack=1 -> WAIT_HDR, guess_valid=0 next cycle; guess retains value.
REQ-027 guess_valid SHALL be 1 only in HOLD.
REQ-028 en_q=0 SHALL force WAIT_HDR next cycle from any state, clear timer, drop guess_valid, leave err_count unchanged.
REQ-029 err_count SHALL saturate at 15; err_clr=1 SHALL set it to 0, winning over a same-cycle increment.
REQ-030 Timer SHALL be wide enough for TIMEOUT_CLKS-1 and SHALL not count outside WAIT_LTR.

Reset
REQ-031 nRst=0 SHALL asynchronously set state=WAIT_HDR, en_q=0, rec_ready=0, guess=8'h00, guess_valid=0, timeout=0, err_count=0, timer=0.
REQ-032 Reset mid-frame SHALL discard any partial header/letter; no guess_valid after release without a new full frame.

Verification
REQ-033 enable=1, pulses 8'h47 then 8'h62 -> guess=8'h42, guess_valid=1 two cycles after letter pulse, held until game_ack, then 0.
REQ-034 8'h47 then no byte for TIMEOUT_CLKS cycles -> one timeout pulse, err_count=1, rec_ready stays 1, state WAIT_HDR.
REQ-035 8'h47 then 8'h31 -> no guess_valid, err_count+1; 8'h47 then 8'h47 then 8'h5A -> guess=8'h5A.
REQ-036 Letter pulse with parity_err=1 -> err_count+1, no guess_valid; 16 such errors -> err_count=15; err_clr -> 0.
REQ-037 rx_ready pulses during HOLD -> ignored, guess unchanged; enable=0 during HOLD -> guess_valid=0 and rec_ready=0 within 2 cycles.
REQ-038 nRst asserted between header and letter -> all outputs at reset values; letter alone after release -> no guess_valid.
